serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Multi-cycle subtractor: computes RSub = Value1 - Value2, DIGIT bits per clock, LSB first.
- Uses two's-complement addition: Value1 + ~Value2 + 1, with the borrow chain held in a flip-flop between cycles.
- Gives a small-area alternative to the 32-bit ripple adder path in the ALU datapath.
- Start/Ready/Done handshake; results and flags stay registered until the next operation is accepted.

Parameters:
- WIDTH, 32, operand and result width in bits.
- DIGIT, 1, bits processed per cycle. Must divide WIDTH; elaboration error otherwise. N = WIDTH/DIGIT.

Ports:
- Clock  input  1  sole clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; accepted only when Ready=1.
- Value1  input  WIDTH  minuend; sampled on the accepting edge only.
- Value2  input  WIDTH  subtrahend; sampled on the accepting edge only.
- Ready  output  1  high in IDLE only.
- Done  output  1  one-cycle pulse; results are valid from this cycle onward.
- RSub  output  WIDTH  difference, modulo 2^WIDTH.
- BorrowOut  output  1  1 iff Value1 < Value2 (unsigned); equals the inverted final carry.
- Overflow  output  1  signed overflow: operand signs differ and result sign differs from Value1 sign.
- Zero  output  1  1 iff RSub == 0.

Behaviour:
- Reset, sampled on a rising edge, has priority over everything, including mid-operation. On reset:
  - state goes to IDLE; Ready=1 and Done=0;
  - RSub, BorrowOut, Overflow and Zero go to 0, and the operation count goes to 0;
  - any in-flight operation is discarded with no Done.
- States: IDLE, RUN, DONE.
- IDLE → RUN on an edge with Start=1:
  - Value1 and ~Value2 are latched into shift registers;
  - the carry flop is set to 1 (this is the +1);
  - the digit counter is cleared to 0.
- IDLE with Start=0: hold all outputs.
- RUN, each edge:
  - add the low DIGIT bits of both shift registers plus the carry flop;
  - shift the DIGIT-bit sum into RSub from the MSB side;
  - update the carry flop and shift the operand registers right by DIGIT;
  - increment the counter.
- RUN → DONE on the edge where counter == N-1, i.e. after N processing edges. On that edge:
  - RSub completes;
  - BorrowOut = ~carry_final;
  - Overflow uses the latched sign bits of Value1 and ~Value2 and the final sum MSB;
  - Zero = (final RSub == 0).
- RSub, BorrowOut, Overflow and Zero change only at that RUN→DONE edge (intermediate partial results are kept in an internal register) and at reset.
- DONE: Done=1 and Ready=0 for exactly one cycle, then unconditionally → IDLE.
- Latency: Start accepted at edge E0, Done high in the cycle after edge E0+N. Ready returns 1 one cycle later. Throughput is one operation per N+2 cycles.
- Start while Ready=0 (RUN or DONE) is ignored, with no queuing. Operand changes after acceptance have no effect.
- Start asserted on the same edge as Reset: Reset wins and the request is dropped.
- Wrap-around: the result is modulo 2^WIDTH with no saturation. 0 - 1 gives all-ones with BorrowOut=1.

Test Plan:
- Reset, then Start with Value1=10, Value2=3 (defaults) → Done exactly 33 cycles after the accept cycle; RSub=0x00000007, BorrowOut=0, Overflow=0, Zero=0; Ready=1 the following cycle.
- Value1=3, Value2=10 → RSub=0xFFFFFFF9, BorrowOut=1, Overflow=0, Zero=0.
- Value1=0x80000000, Value2=1 → RSub=0x7FFFFFFF, Overflow=1, BorrowOut=0. Then Value1=0x12345678 equal to Value2 → RSub=0, Zero=1, BorrowOut=0.
- Start pulsed at RUN cycle 5 with different operands, and operands changed mid-run → ignored; first result unchanged, exactly one Done pulse.
- Reset asserted at RUN cycle 10 → no Done; next cycle Ready=1 and all outputs 0. A new 7-2 request completes with RSub=5.
- DIGIT=4 build, Value1=0, Value2=1 → Done 9 cycles after accept; RSub=0xFFFFFFFF, BorrowOut=1.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for serial_subtractor.
//   master: drives start/value1/value2, observes ready/done/results.
//   slave : the subtractor side.
//   start     request, taken only while ready=1
//   value1    minuend (sampled on the accepting edge)
//   value2    subtrahend (sampled on the accepting edge)
//   ready     high while the subtractor is idle
//   done      one-cycle pulse when results become valid
//   rsub      difference modulo 2^WIDTH
//   borrow_out, overflow, zero  result flags
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] value1;
    logic [WIDTH-1:0] value2;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] rsub;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, value1, value2,
        input  ready, done, rsub, borrow_out, overflow, zero
    );

    modport slave (
        input  start, value1, value2,
        output ready, done, rsub, borrow_out, overflow, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: rsub = value1 - value2, DIGIT bits per clock, LSB first,
// computed as value1 + ~value2 + 1 with the carry kept in a flop between digits.
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    serial_subtractor_if slave (start/ready/done handshake, operands, results)
module serial_subtractor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 1
) (
    input  logic                clock,
    input  logic                reset,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned N  = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = DIGIT + 1;

    // DIGIT must split WIDTH into whole digits
    if ((DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $error("serial_subtractor: DIGIT must be nonzero and divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [WIDTH-1:0]  a_q;        // remaining minuend digits
    logic [WIDTH-1:0]  b_q;        // remaining inverted subtrahend digits
    logic              carry_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  acc_q;      // partial difference, filled from the MSB side
    logic              a_msb_q;
    logic              b_msb_q;

    logic              ready_q;
    logic              done_q;
    logic [WIDTH-1:0]  rsub_q;
    logic              borrow_q;
    logic              ovf_q;
    logic              zero_q;

    logic [DIGIT:0]    sum_c;
    logic [WIDTH-1:0]  acc_c;
    logic              last_c;

    // One digit of the addition and the partial result it produces
    always_comb begin
        sum_c  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + SW'(carry_q);
        acc_c  = (acc_q >> DIGIT) | (WIDTH'(sum_c[DIGIT-1:0]) << (WIDTH - DIGIT));
        last_c = (cnt_q == CW'(N - 1));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_c)    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and handshake outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    // Operand shifting, carry chain and result capture
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            rsub_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.value1;
                        b_q     <= ~bus.value2;
                        carry_q <= 1'b1;   // the +1 of the two's complement
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        a_msb_q <= bus.value1[WIDTH-1];
                        b_msb_q <= ~bus.value2[WIDTH-1];
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= sum_c[DIGIT];
                    cnt_q   <= cnt_q + CW'(1);
                    acc_q   <= acc_c;
                    if (last_c) begin
                        rsub_q   <= acc_c;
                        borrow_q <= ~sum_c[DIGIT];
                        // adding operands of equal sign that yields the other sign
                        ovf_q    <= (a_msb_q == b_msb_q) && (acc_c[WIDTH-1] != a_msb_q);
                        zero_q   <= (acc_c == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.done       = done_q;
    assign bus.rsub       = rsub_q;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = ovf_q;
    assign bus.zero       = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: a DIGIT=1 and a DIGIT=4 instance checked against
// an arithmetic reference model over directed and random operands.
module tb_serial_subtractor;
    localparam int unsigned W   = 32;
    localparam int          N1  = 32;
    localparam int          N4  = 8;
    localparam int          TMO = 200;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   done_cnt1 = 0;

    serial_subtractor_if #(.WIDTH(W)) bus1 ();
    serial_subtractor_if #(.WIDTH(W)) bus4 ();

    serial_subtractor #(.WIDTH(W), .DIGIT(1)) dut1 (.clock(clk), .reset(reset), .bus(bus1));
    serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut4 (.clock(clk), .reset(reset), .bus(bus4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count done pulses of the DIGIT=1 instance
    always @(posedge clk) begin
        if (bus1.done === 1'b1) done_cnt1 <= done_cnt1 + 1;
    end

    // Reference model: plain wide arithmetic
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        longint d;
        d = longint'({32'b0, a}) - longint'({32'b0, b});
        return W'(d);
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
        longint d;
        d = longint'({32'b0, a}) - longint'({32'b0, b});
        return (d < 0);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        longint d;
        d = longint'($signed(a)) - longint'($signed(b));
        return (d > 64'sd2147483647) || (d < -64'sd2147483648);
    endfunction

    // Issue one request on bus1 (called just after an edge with ready=1);
    // returns the number of edges after acceptance until done is seen.
    task automatic op1(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        bus1.value1 = a;
        bus1.value2 = b;
        bus1.start  = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        lat = 0;
        while (bus1.done !== 1'b1 && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus1.start = 1'b0; bus1.value1 = '0; bus1.value2 = '0;
        bus4.start = 1'b0; bus4.value1 = '0; bus4.value2 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (bus1.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus1.ready); end
        checks++; if (bus1.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus1.done); end
        checks++; if (bus1.rsub !== '0) begin errors++; $display("FAIL reset_rsub: got %h want 0", bus1.rsub); end
        checks++; if (bus1.borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b want 0", bus1.borrow_out); end
        checks++; if (bus1.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus1.overflow); end
        checks++; if (bus1.zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", bus1.zero); end
        checks++; if (bus4.ready !== 1'b1) begin errors++; $display("FAIL reset_ready4: got %b want 1", bus4.ready); end
    endtask

    // One full operation with latency, result, flags and ready-return checks
    task automatic test_arith(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        logic [W-1:0] er;
        er = ref_diff(a, b);
        op1(a, b, lat);
        checks++; if (lat != N1) begin errors++; $display("FAIL latency %h-%h: got %0d want %0d", a, b, lat, N1); end
        checks++; if (bus1.rsub !== er) begin errors++; $display("FAIL rsub %h-%h: got %h want %h", a, b, bus1.rsub, er); end
        checks++; if (bus1.borrow_out !== ref_borrow(a, b)) begin errors++; $display("FAIL borrow %h-%h: got %b want %b", a, b, bus1.borrow_out, ref_borrow(a, b)); end
        checks++; if (bus1.overflow !== ref_ovf(a, b)) begin errors++; $display("FAIL ovf %h-%h: got %b want %b", a, b, bus1.overflow, ref_ovf(a, b)); end
        checks++; if (bus1.zero !== (er == '0)) begin errors++; $display("FAIL zero %h-%h: got %b want %b", a, b, bus1.zero, (er == '0)); end
        checks++; if (bus1.ready !== 1'b0) begin errors++; $display("FAIL ready_in_done %h-%h: got %b want 0", a, b, bus1.ready); end
        @(posedge clk); #1;
        checks++; if (bus1.ready !== 1'b1 || bus1.done !== 1'b0) begin errors++; $display("FAIL ready_after %h-%h: got ready=%b done=%b want 1/0", a, b, bus1.ready, bus1.done); end
    endtask

    task automatic test_directed();
        test_arith(32'd10, 32'd3);
        test_arith(32'd3, 32'd10);
        test_arith(32'h8000_0000, 32'd1);
        test_arith(32'h1234_5678, 32'h1234_5678);
        test_arith(32'd0, 32'd1);
        test_arith(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 12; i++) begin
            a = $urandom();
            b = (i % 4 == 3) ? a : W'($urandom());
            test_arith(a, b);
        end
    endtask

    // Start during RUN and operand changes after acceptance must not matter
    task automatic test_ignore_start();
        int lat;
        int d0;
        d0 = done_cnt1;
        bus1.value1 = 32'h0000_1000;
        bus1.value2 = 32'h0000_0001;
        bus1.start  = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus1.start  = 1'b1;
        bus1.value1 = $urandom();
        bus1.value2 = $urandom();
        @(posedge clk); #1;
        bus1.start  = 1'b0;
        bus1.value1 = $urandom();
        bus1.value2 = $urandom();
        lat = 6;
        while (bus1.done !== 1'b1 && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat != N1) begin errors++; $display("FAIL ignore_latency: got %0d want %0d", lat, N1); end
        checks++; if (bus1.rsub !== 32'h0000_0FFF) begin errors++; $display("FAIL ignore_rsub: got %h want 00000fff", bus1.rsub); end
        repeat (N1 + 4) @(posedge clk);
        #1;
        checks++; if (done_cnt1 - d0 != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt1 - d0); end
        checks++; if (bus1.ready !== 1'b1) begin errors++; $display("FAIL ignore_ready: got %b want 1", bus1.ready); end
    endtask

    // Reset in the middle of RUN drops the operation
    task automatic test_reset_midrun();
        int d0;
        bus1.value1 = 32'hDEAD_BEEF;
        bus1.value2 = 32'h0000_0001;
        bus1.start  = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        d0 = done_cnt1;
        checks++; if (bus1.ready !== 1'b1 || bus1.done !== 1'b0) begin errors++; $display("FAIL midrst_hs: got ready=%b done=%b want 1/0", bus1.ready, bus1.done); end
        checks++; if (bus1.rsub !== '0 || bus1.borrow_out !== 1'b0 || bus1.overflow !== 1'b0 || bus1.zero !== 1'b0) begin
            errors++; $display("FAIL midrst_outs: got rsub=%h b=%b o=%b z=%b want all 0", bus1.rsub, bus1.borrow_out, bus1.overflow, bus1.zero);
        end
        repeat (N1 + 4) @(posedge clk);
        #1;
        checks++; if (done_cnt1 != d0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt1 - d0); end
        test_arith(32'd7, 32'd2);
    endtask

    // Start on the same edge as reset is dropped
    task automatic test_reset_with_start();
        int d0;
        bus1.value1 = 32'd50;
        bus1.value2 = 32'd8;
        bus1.start  = 1'b1;
        reset       = 1'b1;
        @(posedge clk); #1;
        reset      = 1'b0;
        bus1.start = 1'b0;
        d0 = done_cnt1;
        repeat (N1 + 4) @(posedge clk);
        #1;
        checks++; if (done_cnt1 != d0 || bus1.rsub !== '0) begin errors++; $display("FAIL rst_start_dropped: got pulses=%0d rsub=%h want 0/0", done_cnt1 - d0, bus1.rsub); end
    endtask

    // Start held high: operations run every N+2 cycles
    task automatic test_back_to_back();
        int lat;
        int gap;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        a2 = $urandom();
        b2 = $urandom();
        bus1.value1 = 32'd100;
        bus1.value2 = 32'd1;
        bus1.start  = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (bus1.done !== 1'b1 && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (bus1.rsub !== 32'd99) begin errors++; $display("FAIL b2b_first: got %h want 00000063", bus1.rsub); end
        bus1.value1 = a2;
        bus1.value2 = b2;
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++;
        end while (bus1.done !== 1'b1 && gap < TMO);
        bus1.start = 1'b0;
        checks++; if (gap != N1 + 2) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", gap, N1 + 2); end
        checks++; if (bus1.rsub !== ref_diff(a2, b2)) begin errors++; $display("FAIL b2b_second: got %h want %h", bus1.rsub, ref_diff(a2, b2)); end
        @(posedge clk); #1;
    endtask

    // DIGIT=4 instance
    task automatic test_digit4();
        int lat;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? 32'd0 : W'($urandom());
            b = (i == 0) ? 32'd1 : W'($urandom());
            bus4.value1 = a;
            bus4.value2 = b;
            bus4.start  = 1'b1;
            @(posedge clk); #1;
            bus4.start = 1'b0;
            lat = 0;
            while (bus4.done !== 1'b1 && lat < TMO) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++; if (lat != N4) begin errors++; $display("FAIL d4_latency %h-%h: got %0d want %0d", a, b, lat, N4); end
            checks++; if (bus4.rsub !== ref_diff(a, b)) begin errors++; $display("FAIL d4_rsub %h-%h: got %h want %h", a, b, bus4.rsub, ref_diff(a, b)); end
            checks++; if (bus4.borrow_out !== ref_borrow(a, b) || bus4.overflow !== ref_ovf(a, b)) begin
                errors++; $display("FAIL d4_flags %h-%h: got b=%b o=%b want b=%b o=%b", a, b, bus4.borrow_out, bus4.overflow, ref_borrow(a, b), ref_ovf(a, b));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_midrun();
        test_reset_with_start();
        test_back_to_back();
        test_digit4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
